// File: rtl/keypad_pkg.sv
// Shared types, keypad geometry and key-code lookup for the keypad scan encoder.
package keypad_pkg;

    localparam int unsigned ROWS_N = 4;
    localparam int unsigned COLS_N = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        KP_SCAN,
        KP_DEBOUNCE,
        KP_HELD,
        KP_RELEASE
    } kp_state_t;

    // Row-major keypad legend, indexed by {row, col}.
    localparam key_code_t KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Index of the lowest active-low row bit (0 when none is low).
    function automatic logic [1:0] low_row(input logic [ROWS_N-1:0] rows);
        logic found;
        found   = 1'b0;
        low_row = '0;
        for (int unsigned i = 0; i < ROWS_N; i++) begin
            if (!rows[i] && !found) begin
                low_row = 2'(i);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic key_code_t key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Key-code delivery channel: show-ahead KEY with a VALID/READY handshake.
interface keypad_scan_encoder_if;
    import keypad_pkg::*;

    key_code_t KEY;
    logic      VALID;
    logic      READY;

    modport master (output KEY, output VALID, input  READY);
    modport slave  (input  KEY, input  VALID, output READY);

endinterface

// File: rtl/keypad_scan_encoder_fifo.sv
// Small synchronous show-ahead FIFO holding accepted key codes.
module kp_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  key_code_t               data_i,
    input  logic                    pop_i,
    output key_code_t               data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

    key_code_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;
    logic          pop_ok;
    logic          push_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

    // Storage, pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, one code per press.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [ROWS_N-1:0]       ROWS,
    output logic [COLS_N-1:0]       COLS,
    output logic                    PRESSED,
    output logic                    OVERFLOW,
    output logic [$clog2(DEPTH):0]  LEVEL,
    keypad_scan_encoder_if.master   kp
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    logic [ROWS_N-1:0] rows_meta_q;
    logic [ROWS_N-1:0] rows_sync_q;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        col_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ROWS_N-1:0] pat_q;
    logic              pressed_q;
    logic              armed_q;
    logic [1:0]        clean_q;
    logic              ovf_q;
    kp_state_t         state_q;

    logic              tick;
    logic              raw_hit;
    logic              all_high;
    logic              match;
    logic              push;
    logic              pop;
    key_code_t         code;
    logic              fifo_full;
    logic              fifo_empty;

    assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign raw_hit  = !(&rows_sync_q);
    assign all_high = &rows_sync_q;
    assign match    = (rows_sync_q == pat_q);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign code     = key_lookup(low_row(rows_sync_q), col_q);

    // Accepting tick: either an immediate accept (single-sample debounce) or the last matching sample.
    assign push = tick && (
                   (state_q == KP_SCAN && raw_hit && armed_q && DEBOUNCE == 1)
                || (state_q == KP_DEBOUNCE && match && cnt_inc == CNT_W'(DEBOUNCE)));

    assign pop      = kp.READY && !fifo_empty;
    assign kp.VALID = !fifo_empty;
    assign COLS     = ~(COLS_N'(1) << col_q);
    assign PRESSED  = pressed_q;
    assign OVERFLOW = ovf_q;

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
        end else begin
            rows_meta_q <= ROWS;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Free-running dwell counter; its terminal count is the row sample tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Scan/debounce FSM. After a release the scanner stays disarmed until one full
    // column sweep sees no key, so a key still held elsewhere is never re-reported.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= KP_SCAN;
            col_q     <= '0;
            cnt_q     <= '0;
            pat_q     <= '1;
            pressed_q <= 1'b0;
            armed_q   <= 1'b1;
            clean_q   <= '0;
        end else if (tick) begin
            unique case (state_q)
                KP_SCAN: begin
                    if (raw_hit && armed_q) begin
                        pat_q <= rows_sync_q;
                        cnt_q <= CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_q   <= KP_HELD;
                            pressed_q <= 1'b1;
                        end else begin
                            state_q <= KP_DEBOUNCE;
                        end
                    end else begin
                        col_q <= col_q + 2'd1;
                        if (raw_hit) begin
                            clean_q <= '0;
                        end else if (!armed_q) begin
                            clean_q <= clean_q + 2'd1;
                            if (clean_q == 2'(COLS_N - 1)) begin
                                armed_q <= 1'b1;
                            end
                        end
                    end
                end
                KP_DEBOUNCE: begin
                    if (match) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            state_q   <= KP_HELD;
                            pressed_q <= 1'b1;
                        end
                    end else begin
                        state_q <= KP_SCAN;
                        cnt_q   <= '0;
                    end
                end
                KP_HELD: begin
                    if (all_high) begin
                        cnt_q <= CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_q   <= KP_SCAN;
                            pressed_q <= 1'b0;
                            armed_q   <= 1'b0;
                            clean_q   <= '0;
                        end else begin
                            state_q <= KP_RELEASE;
                        end
                    end
                end
                KP_RELEASE: begin
                    if (all_high) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            state_q   <= KP_SCAN;
                            cnt_q     <= '0;
                            pressed_q <= 1'b0;
                            armed_q   <= 1'b0;
                            clean_q   <= '0;
                        end
                    end else begin
                        state_q <= KP_HELD;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    // One-cycle pulse when an accepted code finds the FIFO full with no pop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= push && fifo_full && !pop;
        end
    end

    kp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (push),
        .data_i  (code),
        .pop_i   (pop),
        .data_o  (kp.KEY),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (LEVEL)
    );

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Producer side of the keypad-to-UI interface: drives the 4x4 matrix keypad columns, senses rows, debounces, and encodes one 4-bit hex code per physical press.
- Codes are queued in a small FIFO and delivered over a VALID/READY handshake to the float-entry UI.
- A level PRESSED output is also provided for edit-latch logic that triggers on press and release.

Parameters:
- SCAN_DIV, 4, CLK cycles per column dwell / row sample period (must be >=3).
- DEBOUNCE, 3, consecutive identical row samples required to accept a press or a release (>=1).
- DEPTH, 4, FIFO entries (power of 2, >=2).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ROWS  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- COLS  out  4  column drive; exactly one bit low at all times.
- KEY  out  4  FIFO head key code.
- VALID  out  1  FIFO non-empty.
- READY  in  1  consumer accepts KEY when VALID&READY at posedge CLK.
- PRESSED  out  1  high while a debounced key is held.
- OVERFLOW  out  1  one-cycle pulse when a code is dropped because the FIFO is full.
- LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: COLS=4'b1110 (col 0), KEY=0, VALID=0, PRESSED=0, OVERFLOW=0, LEVEL=0, FSM=SCAN, FIFO emptied, all counters 0. Reset mid-operation discards FIFO contents and any in-progress debounce.
- ROWS passes through a 2-flop synchronizer.
- The dwell counter counts 0..SCAN_DIV-1. At terminal count, the synchronized rows are sampled ("sample tick").
- In SCAN only, the column index advances 0->1->2->3->0 on the same tick. COLS = ~(1<<col).
- Raw hit: any sampled row bit is 0. Row = lowest-index low bit. Code = KEYMAP[{row,col}].
- KEYMAP, row-major: 1,2,3,A / 4,5,6,B / 7,8,9,C / E(*),0,F(#),D.
- FSM (all transitions on sample ticks):
  - SCAN: on a hit, freeze the column, latch the row pattern, set cnt=1, go to DEBOUNCE. If DEBOUNCE=1, go directly to HELD.
  - DEBOUNCE: if the sample equals the latched pattern, cnt++; when cnt reaches DEBOUNCE, go to HELD and push the code. Any mismatch returns to SCAN (column resumes advancing).
  - HELD: PRESSED=1. Column stays frozen, so other keys are ignored. A sample with all rows high sets cnt=1 and moves to RELEASE.
  - RELEASE: PRESSED stays 1. An all-high sample does cnt++; at DEBOUNCE, PRESSED=0 and go to SCAN. Any low sample returns to HELD without a new push.
- Exactly one push per accepted press. No auto-repeat.
- Push occurs on the cycle of the accepting tick. VALID/KEY update the next cycle (show-ahead head register).
- Pop occurs on VALID&READY.
- Full FIFO with push and no pop: drop the code, OVERFLOW=1 for one cycle, contents unchanged.
- Full FIFO with simultaneous push and pop: both succeed, LEVEL unchanged.
- Empty FIFO with push: VALID rises next cycle. READY while VALID=0 is ignored.
- Pointers wrap modulo DEPTH. LEVEL never exceeds DEPTH.

Decomposition:
- Package keypad_pkg:
  - key_code_t (logic[3:0]).
  - kp_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - KEYMAP constant (16 x key_code_t, indexed {row,col}).
  - ROWS_N=4, COLS_N=4.
- Sub-module kp_fifo: synchronous show-ahead FIFO, parameter DEPTH, with push/pop/full/empty/level. Overflow detection sits in the parent.

Test Plan:
- Reset: hold RESET_N=0, ROWS=4'hF -> COLS=4'b1110, VALID=0, PRESSED=0, LEVEL=0. After release, COLS cycles E,D,B,7 every 4 CLK.
- Clean press: key '5' held (ROWS[1]=0 when col 1 driven) for 20 ticks, READY=0 -> LEVEL=1, KEY=4'h5, PRESSED=1. Release -> PRESSED falls on the 3rd all-high tick, LEVEL stays 1. Pulse READY -> LEVEL=0, VALID=0.
- Bounce: '#' (row 3, col 2) toggling every tick for 10 ticks -> no push. Then stable for 3 ticks -> exactly one entry, KEY=4'hF.
- Overflow: DEPTH=4, READY=0, clean presses 1,2,3,A,4 -> LEVEL=4, OVERFLOW pulses once on the 5th. Draining with READY=1 yields 1,2,3,A. Repeat with READY=1 asserted on the push cycle of a full FIFO -> no OVERFLOW, LEVEL stays 4.
- Multi-key: '1' and '4' pressed together (col 0, rows 0 and 1) -> single code 1. '2' held, then '3' added and '2' released while '3' is held -> no new code until all keys are released and '3' is re-pressed.
- Reset mid-HELD: '7' held, LEVEL=2, assert RESET_N=0 for 3 cycles -> LEVEL=0, PRESSED=0. After deassert with '7' still held -> exactly one new entry 4'h7.
